// File: rtl/mpadd_seq_ctrl_pkg.sv
// Shared constants for the multi-precision add/subtract sequencer:
// FSM state encoding, ALU op codes and the adder word width.
package mpadd_seq_ctrl_pkg;

  localparam int WORD_W = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mpadd_seq_ctrl.sv
// Multi-precision add/subtract sequencer: drives an external 16-bit adder one word per
// cycle, LSW first, chaining the carry. Optional MSW signed overflow via `MPADD_OVF_EN.
module mpadd_seq_ctrl
  import mpadd_seq_ctrl_pkg::*;
#(
  parameter int WORDS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_op,
  input  logic                      in_use_cin,
  input  logic                      in_cin,
  input  logic [WORDS*WORD_W-1:0]   in_a,
  input  logic [WORDS*WORD_W-1:0]   in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORDS*WORD_W-1:0]   out_sum,
  output logic                      out_cout,
  output logic                      out_z,
  output logic [WORD_W-1:0]         fa_a,
  output logic [WORD_W-1:0]         fa_b,
  output logic                      fa_aluop,
  output logic                      fa_psw_c,
  output logic                      fa_flag,
  input  logic [WORD_W-1:0]         fa_sum,
  input  logic                      fa_cout,
  input  logic                      fa_z
`ifdef MPADD_OVF_EN
  ,
  output logic                      out_ovf
`endif
);

  localparam int                 OPND_W   = WORDS * WORD_W;
  localparam int                 IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORDS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [OPND_W-1:0]   a_q, a_d;
  logic [OPND_W-1:0]   b_q, b_d;
  logic [OPND_W-1:0]   sum_q, sum_d;
  logic                op_q, op_d;
  logic                use_cin_q, use_cin_d;
  logic                cin_q, cin_d;
  logic                carry_q, carry_d;
  logic                z_acc_q, z_acc_d;
  logic [WORD_W-1:0]   cur_a, cur_b;

  assign cur_a = a_q[idx_q*WORD_W +: WORD_W];
  assign cur_b = b_q[idx_q*WORD_W +: WORD_W];

`ifdef MPADD_OVF_EN
  logic ovf_q, ovf_d;
  logic b_eff_msb;

  // For subtraction the adder sees ~B, so the effective B sign flips.
  assign b_eff_msb = cur_b[WORD_W-1] ^ (op_q == OP_SUB);
  assign out_ovf   = ovf_q;
`endif

  // NOTE: every state-holding register uses non-blocking assignment so all
  // registers sample the same pre-edge values; blocking here would race.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      op_q      <= OP_ADD;
      use_cin_q <= 1'b0;
      cin_q     <= 1'b0;
      carry_q   <= 1'b0;
      z_acc_q   <= 1'b0;
`ifdef MPADD_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      op_q      <= op_d;
      use_cin_q <= use_cin_d;
      cin_q     <= cin_d;
      carry_q   <= carry_d;
      z_acc_q   <= z_acc_d;
`ifdef MPADD_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    op_d      = op_q;
    use_cin_d = use_cin_q;
    cin_d     = cin_q;
    carry_d   = carry_q;
    z_acc_d   = z_acc_q;
`ifdef MPADD_OVF_EN
    ovf_d     = ovf_q;
`endif
    fa_a      = '0;
    fa_b      = '0;
    fa_aluop  = 1'b0;
    fa_psw_c  = 1'b0;
    fa_flag   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d       = in_a;
          b_d       = in_b;
          op_d      = in_op;
          use_cin_d = in_use_cin;
          cin_d     = in_cin;
          idx_d     = '0;
          z_acc_d   = 1'b1;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        fa_a     = cur_a;
        fa_b     = cur_b;
        fa_aluop = op_q;
        // Word 0 takes the caller's carry policy; later words chain the stored carry.
        if (idx_q == '0) begin
          fa_flag  = use_cin_q;
          fa_psw_c = cin_q;
        end else begin
          fa_flag  = 1'b1;
          fa_psw_c = carry_q;
        end

        sum_d[idx_q*WORD_W +: WORD_W] = fa_sum;
        carry_d = fa_cout;
        z_acc_d = z_acc_q & fa_z;

        if (idx_q == LAST_IDX) begin
`ifdef MPADD_OVF_EN
          ovf_d   = (cur_a[WORD_W-1] == b_eff_msb) && (fa_sum[WORD_W-1] != cur_a[WORD_W-1]);
`endif
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;
  assign out_z     = z_acc_q;

endmodule
